clc_encoder: RTL and testbench

CLC_ENCODER -- requirements
Module: clc_encoder

---
 rtl/clc_encoder.sv | 122 ++++++++++++
 tb/tb_clc_encoder.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/clc_encoder.sv
`default_nettype none
// ============================================================================
// Module   : clc_encoder
// Purpose  : Two-stage valid/ready pipeline producing 32-bit CLC codewords
//            (transposed data field plus row, quadrant and diagonal parity).
// Revision : 1.0
// ============================================================================
module clc_encoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [0:15]      data_in,
  input  logic [0:31]      inj_mask,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [0:31]      code_out,
  output logic [CNT_W-1:0] word_cnt
);

  logic             s1_valid_q, s1_valid_d;
  logic [0:15]      s1_data_q, s1_data_d;
  logic [0:31]      s1_mask_q, s1_mask_d;
  logic             s2_valid_q, s2_valid_d;
  logic [0:31]      s2_code_q, s2_code_d;
  logic [CNT_W-1:0] word_cnt_q, word_cnt_d;

  logic             s2_free;
  logic             in_fire;
  logic             out_fire;
  logic             s [0:3][0:3];
  logic [0:15]      red;
  logic [0:31]      enc_word;

  always_comb begin
    s2_free  = !s2_valid_q || out_ready;
    // Reset forces ready high; in_fire masks it so nothing is captured.
    in_ready = rst || !s1_valid_q || s2_free;
    in_fire  = in_valid && in_ready && !rst;
    out_fire = s2_valid_q && out_ready;
  end

  always_comb begin
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        s[r][c] = s1_data_q[4*r+c];
      end
    end
    enc_word = '0;
    red      = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        enc_word[r+4*c] = s[r][c];
      end
      red[8+2*r] = s[r][0] ^ s[r][2];
      red[9+2*r] = s[r][1] ^ s[r][3];
    end
    red[4] = s[0][0] ^ s[0][1] ^ s[1][0] ^ s[1][1];
    red[5] = s[2][2] ^ s[2][3] ^ s[3][2] ^ s[3][3];
    red[6] = s[2][0] ^ s[2][1] ^ s[3][0] ^ s[3][1];
    red[7] = s[0][2] ^ s[0][3] ^ s[1][2] ^ s[1][3];
    red[0] = s[0][0] ^ s[1][1] ^ s[2][0] ^ s[3][1];
    red[1] = s[0][3] ^ s[1][2] ^ s[2][3] ^ s[3][2];
    red[2] = s[0][1] ^ s[1][0] ^ s[2][1] ^ s[3][0];
    red[3] = s[0][2] ^ s[1][3] ^ s[2][2] ^ s[3][3];
    enc_word[16:31] = red;
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_mask_d  = s1_mask_q;
    s2_valid_d = s2_valid_q;
    s2_code_d  = s2_code_q;
    word_cnt_d = word_cnt_q;

    if (in_fire) begin
      s1_valid_d = 1'b1;
      s1_data_d  = data_in;
      s1_mask_d  = inj_mask;
    end else if (s1_valid_q && s2_free) begin
      s1_valid_d = 1'b0;
    end

    if (s2_free) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_code_d = enc_word ^ s1_mask_q;
      end
    end

    if (out_fire) begin
      word_cnt_d = word_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_mask_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_code_q  <= '0;
      word_cnt_q <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s1_mask_q  <= s1_mask_d;
      s2_valid_q <= s2_valid_d;
      s2_code_q  <= s2_code_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign code_out  = s2_code_q;
  assign word_cnt  = word_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_clc_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_clc_encoder
// Purpose  : Directed self-checking bench for clc_encoder.
// Revision : 1.0
// ============================================================================
module tb_clc_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [0:15] data_in = '0;
  logic [0:31] inj_mask = '0;
  logic        out_ready = 1'b0;

  logic        in_ready, out_valid;
  logic [0:31] code_out;
  logic [15:0] word_cnt;
  logic        in_ready4, out_valid4;
  logic [0:31] code_out4;
  logic [3:0]  word_cnt4;

  int total = 0;
  int bad = 0;
  int exp_cnt = 0;
  logic [0:31] exp_q[$];

  always #5 clk = ~clk;

  clc_encoder #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .data_in(data_in), .inj_mask(inj_mask), .out_valid(out_valid),
    .out_ready(out_ready), .code_out(code_out), .word_cnt(word_cnt)
  );

  clc_encoder #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
    .data_in(data_in), .inj_mask(inj_mask), .out_valid(out_valid4),
    .out_ready(out_ready), .code_out(code_out4), .word_cnt(word_cnt4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [0:31] model(input logic [0:15] d);
    logic        sm [0:3][0:3];
    logic [0:15] rd;
    logic [0:31] cw;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        sm[r][c]     = d[4*r+c];
        cw[r+4*c]    = d[4*r+c];
      end
    for (int r = 0; r < 4; r++) begin
      rd[8+2*r] = sm[r][0] ^ sm[r][2];
      rd[9+2*r] = sm[r][1] ^ sm[r][3];
    end
    rd[4] = sm[0][0] ^ sm[0][1] ^ sm[1][0] ^ sm[1][1];
    rd[5] = sm[2][2] ^ sm[2][3] ^ sm[3][2] ^ sm[3][3];
    rd[6] = sm[2][0] ^ sm[2][1] ^ sm[3][0] ^ sm[3][1];
    rd[7] = sm[0][2] ^ sm[0][3] ^ sm[1][2] ^ sm[1][3];
    rd[0] = sm[0][0] ^ sm[1][1] ^ sm[2][0] ^ sm[3][1];
    rd[1] = sm[0][3] ^ sm[1][2] ^ sm[2][3] ^ sm[3][2];
    rd[2] = sm[0][1] ^ sm[1][0] ^ sm[2][1] ^ sm[3][0];
    rd[3] = sm[0][2] ^ sm[1][3] ^ sm[2][2] ^ sm[3][3];
    cw[16:31] = rd;
    return cw;
  endfunction

  // One cycle of stimulus: drive 2 time units after the edge, settle, then
  // note whether the upcoming edge completes an input handshake.
  task automatic step(input logic v, input logic [0:15] d, input logic [0:31] m,
                      input logic ordy, output logic acc);
    @(posedge clk);
    #2;
    in_valid  = v;
    data_in   = d;
    inj_mask  = m;
    out_ready = ordy;
    #1;
    acc = v && in_ready && !rst;
    if (acc) exp_q.push_back(model(d) ^ m);
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #2;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b0;
    exp_q.delete();
    exp_cnt = 0;
    #1;
  endtask

  task automatic drain();
    logic acc;
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) step(1'b0, '0, '0, 1'b1, acc);
    check("drain_empty", exp_q.size(), 0);
    step(1'b0, '0, '0, 1'b0, acc);
  endtask

  task automatic single(input string tag, input logic [0:15] d, input logic [0:31] m,
                        input logic [0:31] exp);
    logic acc;
    step(1'b1, d, m, 1'b0, acc);
    check({tag, "_acc"}, acc, 1);
    step(1'b0, '0, '0, 1'b0, acc);
    check({tag, "_lat_n"}, out_valid, 0);
    step(1'b0, '0, '0, 1'b0, acc);
    step(1'b0, '0, '0, 1'b0, acc);
    check({tag, "_vld"}, out_valid, 1);
    check({tag, "_code"}, code_out, exp);
    step(1'b0, '0, '0, 1'b1, acc);
    step(1'b0, '0, '0, 1'b0, acc);
    check({tag, "_empty"}, out_valid, 0);
  endtask

  // Output monitor: scoreboard comparison and hold-while-stalled check.
  logic        hold_valid = 1'b0;
  logic [0:31] hold_code = '0;
  always begin
    @(posedge clk);
    #4;
    if (!rst && hold_valid) check("hold", code_out, hold_code);
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) check("stale_word", 1, 0);
      else check("stream_code", code_out, exp_q.pop_front());
      exp_cnt++;
    end
    hold_valid = !rst && out_valid && !out_ready;
    hold_code  = code_out;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got=running exp=finished");
    $fatal(1, "timeout");
  end

  logic [0:15] vec [0:7];
  initial begin
    logic acc;
    int   idx, cyc;
    logic saw_stall;

    vec[0] = 16'h1234; vec[1] = 16'hABCD; vec[2] = 16'h0F0F; vec[3] = 16'hF0F0;
    vec[4] = 16'h5555; vec[5] = 16'hAAAA; vec[6] = 16'h0001; vec[7] = 16'h8421;

    // Reset with a valid word presented: nothing may be captured.
    in_valid = 1'b1; data_in = 16'h8000;
    repeat (3) @(posedge clk);
    #3;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_code", code_out, 32'h0000_0000);
    check("rst_cnt", word_cnt, 0);
    rst = 1'b0; in_valid = 1'b0;
    step(1'b0, '0, '0, 1'b0, acc);
    step(1'b0, '0, '0, 1'b0, acc);
    check("rst_nothing_stored", out_valid, 0);

    single("zero",  16'h0000, 32'h0, 32'h0000_0000);
    single("ffff",  16'hFFFF, 32'h0, 32'hFFFF_0000);
    single("h8000", 16'h8000, 32'h0, 32'h8000_8880);
    single("h4000", 16'h4000, 32'h0, 32'h0800_2840);
    single("h0001", 16'h0001, 32'h0, 32'h0001_1401);
    single("inj",   16'h8000, 32'h0000_0001, 32'h8000_8881);
    check("single_cnt", word_cnt, 6);

    // Eight-word stream with a five-cycle downstream stall.
    apply_reset();
    idx = 0; cyc = 0; saw_stall = 1'b0;
    while (idx < 8 && cyc < 60) begin
      step(1'b1, vec[idx], '0, !(cyc >= 3 && cyc < 8), acc);
      if (!in_ready) saw_stall = 1'b1;
      if (acc) idx++;
      cyc++;
    end
    check("stream_accepted", idx, 8);
    check("stream_stall_seen", saw_stall, 1);
    drain();
    check("stream_cnt", word_cnt, 8);
    check("stream_cnt_model", word_cnt, exp_cnt);

    // Reset with two words in flight.
    apply_reset();
    step(1'b1, 16'h8000, '0, 1'b0, acc);
    step(1'b1, 16'h4000, '0, 1'b0, acc);
    apply_reset();
    check("midrst_out_valid", out_valid, 0);
    check("midrst_cnt", word_cnt, 0);
    repeat (5) step(1'b0, '0, '0, 1'b1, acc);
    check("midrst_no_stale", out_valid, 0);
    check("midrst_cnt_after", word_cnt, 0);

    // 17 output handshakes: 4-bit counter wraps to 1.
    apply_reset();
    idx = 0; cyc = 0;
    while (idx < 17 && cyc < 60) begin
      step(1'b1, 16'(idx * 16'h0913), '0, 1'b1, acc);
      if (acc) idx++;
      cyc++;
    end
    check("wrap_accepted", idx, 17);
    drain();
    check("wrap_cnt4", word_cnt4, 1);
    check("wrap_cnt16", word_cnt, 17);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
